line_buffer_reader: RTL and testbench

Read-side controller for the 4096×12 simple dual-port line-buffer RAM in the upscaler datapath. The capture side writes one source scanline into the RAM. This block reads a programmed span back out over the RAM read port, replicates each pixel horizontally by a programmable factor, and delivers a valid/ready pixel stream to the output scaler. It absorbs the RAM's 1-cycle read latency with a small prefetch FIFO, so backpressure never loses or duplicates a pixel.

---
 rtl/line_buffer_reader.sv | 146 ++++++++++++++
 tb/tb_line_buffer_reader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_reader.sv
// Read-side controller for the line-buffer RAM: streams a programmed span out of the
// RAM read port, repeats each pixel h_scale+1 times, and presents it as a valid/ready stream.
module line_buffer_reader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   pix_count,
  input  logic [2:0]        h_scale,
  output logic              busy,
  output logic              done,
  output logic              rd_ce,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] px_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic              px_last
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rd_rem_q, rd_rem_d;
  logic [ADDR_W:0]     px_rem_q, px_rem_d;
  logic [2:0]          hs_q, hs_d;
  logic [2:0]          rep_q, rep_d;
  logic                done_q, done_d;
  logic                inflight_q;
  logic [DATA_W-1:0]   fifo_mem [4];
  logic [1:0]          wr_ptr_q, rd_ptr_q;
  logic [2:0]          cnt_q;
  logic [ADDR_W:0]     count_clamped;
  logic                push, pop, fire, head_done;

  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] c);
    if (c[ADDR_W] && (c[ADDR_W-1:0] != '0)) return {1'b1, {ADDR_W{1'b0}}};
    return c;
  endfunction

  assign count_clamped = clamp_count(pix_count);

  // Gate uses registered occupancy plus the read in flight, so FIFO depth 4 can never overflow.
  assign rd_ce     = (state_q == RUN) && (rd_rem_q != '0) &&
                     ((cnt_q + {2'b00, inflight_q}) <= 3'd2);
  assign rd_addr   = addr_q;
  assign push      = inflight_q;
  assign px_valid  = (cnt_q != 3'd0);
  assign fire      = px_valid && px_ready;
  assign head_done = (rep_q == hs_q);
  assign pop       = fire && head_done;
  assign px_last   = px_valid && (px_rem_q == CNT_ONE) && head_done;
  assign px_data   = px_valid ? fifo_mem[rd_ptr_q] : '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rd_rem_d = rd_rem_q;
    px_rem_d = px_rem_q;
    hs_d     = hs_q;
    rep_d    = rep_q;
    done_d   = 1'b0;

    if (rd_ce) begin
      addr_d   = addr_q + ADDR_ONE;
      rd_rem_d = rd_rem_q - CNT_ONE;
    end
    if (fire) rep_d = pop ? 3'd0 : rep_q + 3'd1;
    if (pop)  px_rem_d = px_rem_q - CNT_ONE;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          rd_rem_d = count_clamped;
          px_rem_d = count_clamped;
          hs_d     = h_scale;
          rep_d    = 3'd0;
          if (count_clamped != '0) state_d = RUN;
          else                     done_d  = 1'b1;
        end
      end
      RUN: begin
        if (rd_ce && (rd_rem_q == CNT_ONE)) state_d = FLUSH;
      end
      FLUSH: begin
        if (fire && px_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rd_rem_q   <= '0;
      px_rem_q   <= '0;
      hs_q       <= 3'd0;
      rep_q      <= 3'd0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      cnt_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_rem_q   <= rd_rem_d;
      px_rem_q   <= px_rem_d;
      hs_q       <= hs_d;
      rep_q      <= rep_d;
      done_q     <= done_d;
      inflight_q <= rd_ce;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // RAM dout lands here one cycle after rd_ce; storage is data-only, no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= rd_data;
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (cnt_q >= 3'd4)));
  a_fifo_occ_max: assert property (@(posedge clk) disable iff (reset) cnt_q <= 3'd3);

endmodule

// File: tb/tb_line_buffer_reader.sv
// Scoreboard bench for line_buffer_reader with a behavioural 4096x12 RAM holding RAM[i]=i.
module tb_line_buffer_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] pix_count;
  logic [2:0]  h_scale;
  logic        busy, done, rd_ce;
  logic [11:0] rd_addr;
  logic [11:0] rd_data;
  logic [11:0] px_data;
  logic        px_valid, px_ready, px_last;

  line_buffer_reader #(.ADDR_W(12), .DATA_W(12)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .pix_count(pix_count), .h_scale(h_scale), .busy(busy), .done(done),
    .rd_ce(rd_ce), .rd_addr(rd_addr), .rd_data(rd_data), .px_data(px_data),
    .px_valid(px_valid), .px_ready(px_ready), .px_last(px_last)
  );

  typedef struct {
    logic [11:0] data;
    logic        last;
    logic        pop;
  } exp_t;

  logic [11:0] ram [4096];
  exp_t        exp_q[$];
  int          addr_log[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          c0 = 0;
  int          beats, lasts, rdces, valid_seen, first_rel, done_rel;
  int          occ = 0;
  int          infl = 0;
  logic        stall_prev = 1'b0;
  logic [11:0] prev_data;
  logic        prev_last;
  logic        bp_mode = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  always @(posedge clk) begin
    if (rd_ce) rd_data <= ram[rd_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_stats();
    beats = 0; lasts = 0; rdces = 0; valid_seen = 0; first_rel = -1; done_rel = -1;
    addr_log.delete();
  endtask

  task automatic do_start(input int base, input int cnt, input int hs);
    int n;
    @(posedge clk); #1;
    clear_stats();
    c0 = cyc;
    n = (cnt > 4096) ? 4096 : cnt;
    for (int i = 0; i < n; i++) begin
      for (int r = 0; r <= hs; r++) begin
        exp_t e;
        e.data = ram[(base + i) % 4096];
        e.last = (i == n - 1) && (r == hs);
        e.pop  = (r == hs);
        exp_q.push_back(e);
      end
    end
    start = 1'b1; base_addr = 12'(base); pix_count = 13'(cnt); h_scale = 3'(hs);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        done_rel = cyc - c0;
        seen = 1'b1;
        break;
      end
    end
    check_eq("done_seen", seen, 1);
  endtask

  task automatic run_span(input int base, input int cnt, input int hs, input int exp_done);
    int n;
    n = (cnt > 4096) ? 4096 : cnt;
    do_start(base, cnt, hs);
    h_scale = 3'(hs ^ 5);
    check_eq("c1_busy", busy, 1);
    check_eq("c1_rd_ce", rd_ce, 1);
    check_eq("c1_rd_addr", rd_addr, base % 4096);
    wait_done(20000);
    if (exp_done >= 0) begin
      check_eq("first_beat_cyc", first_rel, 3);
      check_eq("done_cyc", done_rel, exp_done);
    end
    check_eq("busy_at_done", busy, 0);
    check_eq("beats", beats, n * (hs + 1));
    check_eq("last_count", lasts, 1);
    check_eq("read_count", rdces, n);
    check_eq("sb_left", exp_q.size(), 0);
  endtask

  // Monitor: scoreboard compare on handshakes plus an independent FIFO occupancy model.
  initial forever begin
    exp_t e;
    bit   pop_now;
    @(negedge clk);
    if (reset) begin
      occ = 0; infl = 0; stall_prev = 1'b0;
    end else begin
      pop_now = 1'b0;
      check_eq("valid_vs_occ", px_valid, occ != 0);
      if (stall_prev && px_valid) begin
        check_eq("stall_data", px_data, prev_data);
        check_eq("stall_last", px_last, prev_last);
      end
      if (px_valid && px_ready) begin
        beats++;
        if (first_rel < 0) first_rel = cyc - c0;
        if (px_last) lasts++;
        check_eq("sb_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("px_data", px_data, e.data);
          check_eq("px_last", px_last, e.last);
          pop_now = e.pop;
        end
      end
      if (px_valid) valid_seen++;
      if (rd_ce) begin
        rdces++;
        addr_log.push_back(int'(rd_addr));
        check_eq("rd_gate", (occ + infl) <= 2, 1);
      end
      occ  = occ + infl - (pop_now ? 1 : 0);
      infl = rd_ce ? 1 : 0;
      check_eq("occ_max", occ <= 3, 1);
      stall_prev = px_valid && !px_ready;
      prev_data  = px_data;
      prev_last  = px_last;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 12'(i);
    rd_data = '0;
    clear_stats();
    reset = 1'b1; start = 1'b0; base_addr = '0; pix_count = '0; h_scale = '0; px_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rd_ce", rd_ce, 0);
    check_eq("rst_rd_addr", rd_addr, 0);
    check_eq("rst_px_valid", px_valid, 0);
    check_eq("rst_px_last", px_last, 0);
    check_eq("rst_px_data", px_data, 0);
    reset = 1'b0;

    run_span(0, 8, 0, 11);
    run_span(100, 2, 2, 9);

    bp_mode = 1'b1;
    fork
      begin
        forever begin
          @(posedge clk); #1;
          if (!bp_mode) break;
          px_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    run_span(0, 16, 0, -1);
    bp_mode = 1'b0;
    @(posedge clk); #1;
    px_ready = 1'b1;

    run_span(4094, 4, 0, 7);
    check_eq("wrap_addr0", addr_log[0], 4094);
    check_eq("wrap_addr1", addr_log[1], 4095);
    check_eq("wrap_addr2", addr_log[2], 0);
    check_eq("wrap_addr3", addr_log[3], 1);

    run_span(0, 5000, 0, 3 + 4096);

    do_start(0, 0, 0);
    check_eq("zero_done_c1", done, 1);
    check_eq("zero_busy_c1", busy, 0);
    check_eq("zero_rd_ce_c1", rd_ce, 0);
    repeat (3) @(negedge clk);
    check_eq("zero_done_after", done, 0);
    check_eq("zero_valid_seen", valid_seen, 0);
    check_eq("zero_reads", rdces, 0);

    do_start(0, 8, 0);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 12'd50; pix_count = 13'd3; h_scale = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200);
    check_eq("ign_done_cyc", done_rel, 11);
    check_eq("ign_beats", beats, 8);
    check_eq("ign_reads", rdces, 8);
    check_eq("ign_sb_left", exp_q.size(), 0);

    do_start(0, 16, 1);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_rd_ce", rd_ce, 0);
    check_eq("mid_rst_rd_addr", rd_addr, 0);
    check_eq("mid_rst_px_valid", px_valid, 0);
    check_eq("mid_rst_px_last", px_last, 0);
    check_eq("mid_rst_px_data", px_data, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("post_rst_no_done", done, 0);
    end
    run_span(0, 8, 0, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
